// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: RAW stalls, branch flushes, data-memory wait/timeout FSM.
// Build option: define FORWARDING_EN for load-use-only stalls with forwarding active.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  id_src1,
  input  logic [2:0]  id_src2,
  input  logic        id_src1_valid,
  input  logic        id_src2_valid,
  input  logic [2:0]  ex_dest,
  input  logic [2:0]  mem_dest,
  input  logic        ex_wb_en,
  input  logic        mem_wb_en,
  input  logic        ex_is_ld,
  input  logic        branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_freeze,
  output logic        if_id_freeze,
  output logic        id_ex_freeze,
  output logic        ex_mem_freeze,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        mem_wb_bubble,
  output logic        hazard_en,
  output logic        halted,
  output logic        mem_err,
  output logic [15:0] stall_cnt,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    HALT     = 2'b10
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(MEM_TIMEOUT - 1);

  state_t     st;
  logic [3:0] wait_cnt;
  logic       raw_hazard;
  logic       unused_inputs;

  // Register 0 is hard-wired, so it never carries a dependency.
  function automatic logic match(input logic [2:0] d,
                                 input logic [2:0] s1, input logic v1,
                                 input logic [2:0] s2, input logic v2);
    return (d != 3'd0) && ((v1 && (s1 == d)) || (v2 && (s2 == d)));
  endfunction

`ifdef FORWARDING_EN
  assign hazard_en     = 1'b0;
  assign raw_hazard    = ex_is_ld && ex_wb_en &&
                         match(ex_dest, id_src1, id_src1_valid, id_src2, id_src2_valid);
  assign unused_inputs = ^{mem_wb_en, mem_dest};
`else
  assign hazard_en     = 1'b1;
  assign raw_hazard    = (ex_wb_en  && match(ex_dest,  id_src1, id_src1_valid, id_src2, id_src2_valid)) ||
                         (mem_wb_en && match(mem_dest, id_src1, id_src1_valid, id_src2, id_src2_valid));
  assign unused_inputs = ex_is_ld;
`endif

  assign state  = st;
  assign halted = (st == HALT);

  // Control outputs respond in the same cycle as the condition; all quiet under reset.
  always_comb begin
    pc_freeze     = 1'b0;
    if_id_freeze  = 1'b0;
    id_ex_freeze  = 1'b0;
    ex_mem_freeze = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    mem_wb_bubble = 1'b0;
    if (!rst) begin
      if (st != RUN || (mem_req && !mem_ready)) begin
        pc_freeze     = 1'b1;
        if_id_freeze  = 1'b1;
        id_ex_freeze  = 1'b1;
        ex_mem_freeze = 1'b1;
        mem_wb_bubble = 1'b1;
      end else if (branch_taken) begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end else if (raw_hazard) begin
        pc_freeze    = 1'b1;
        if_id_freeze = 1'b1;
        id_ex_bubble = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= RUN;
      wait_cnt  <= 4'd0;
      mem_err   <= 1'b0;
      stall_cnt <= 16'd0;
    end else begin
      if (pc_freeze && st != HALT && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
      case (st)
        RUN: begin
          if (mem_req && !mem_ready) begin
            st       <= MEM_WAIT;
            wait_cnt <= 4'd0;
          end
        end
        MEM_WAIT: begin
          // A completion on the last allowed cycle beats the timeout.
          if (mem_ready) begin
            st <= RUN;
          end else if (wait_cnt == WAIT_LAST) begin
            st      <= HALT;
            mem_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        HALT:    st <= HALT;
        default: st <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl; expectations follow the FORWARDING_EN build setting.
module tb_hazard_ctrl;

`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  localparam logic [7:0] C_NONE = 8'b0000_0000;
  localparam logic [7:0] C_MEM  = 8'b1111_0010;
  localparam logic [7:0] C_BR   = 8'b0000_1100;
  localparam logic [7:0] C_RAW  = 8'b1100_0100;
  localparam logic [7:0] C_HALT = 8'b1111_0011;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  id_src1, id_src2, ex_dest, mem_dest;
  logic        id_src1_valid, id_src2_valid, ex_wb_en, mem_wb_en, ex_is_ld;
  logic        branch_taken, mem_req, mem_ready;
  logic        pc_freeze, if_id_freeze, id_ex_freeze, ex_mem_freeze;
  logic        if_id_flush, id_ex_bubble, mem_wb_bubble, hazard_en, halted, mem_err;
  logic [15:0] stall_cnt;
  logic [1:0]  state;
  logic [7:0]  ctl;

  int checks   = 0;
  int failures = 0;
  int exp_sc   = 0;

  hazard_ctrl #(.MEM_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .id_src1(id_src1), .id_src2(id_src2),
    .id_src1_valid(id_src1_valid), .id_src2_valid(id_src2_valid),
    .ex_dest(ex_dest), .mem_dest(mem_dest),
    .ex_wb_en(ex_wb_en), .mem_wb_en(mem_wb_en), .ex_is_ld(ex_is_ld),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_freeze(pc_freeze), .if_id_freeze(if_id_freeze),
    .id_ex_freeze(id_ex_freeze), .ex_mem_freeze(ex_mem_freeze),
    .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
    .mem_wb_bubble(mem_wb_bubble), .hazard_en(hazard_en),
    .halted(halted), .mem_err(mem_err), .stall_cnt(stall_cnt), .state(state)
  );

  always #5 clk = ~clk;

  assign ctl = {pc_freeze, if_id_freeze, id_ex_freeze, ex_mem_freeze,
                if_id_flush, id_ex_bubble, mem_wb_bubble, halted};

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    id_src1 = 3'd0; id_src2 = 3'd0; id_src1_valid = 1'b0; id_src2_valid = 1'b0;
    ex_dest = 3'd0; mem_dest = 3'd0; ex_wb_en = 1'b0; mem_wb_en = 1'b0;
    ex_is_ld = 1'b0; branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    // Reset with provoking inputs: controls must stay quiet.
    mem_req = 1'b1; branch_taken = 1'b1;
    tick();
    #2;
    check("rst_ctl", 16'(ctl), 16'(C_NONE));
    check("rst_state", 16'(state), 16'd0);
    check("rst_stall_cnt", stall_cnt, 16'd0);
    check("rst_mem_err", 16'(mem_err), 16'd0);
    check("hazard_en", 16'(hazard_en), FWD ? 16'd0 : 16'd1);
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Load-use, one cycle.
    ex_is_ld = 1'b1; ex_wb_en = 1'b1; ex_dest = 3'd3; id_src1 = 3'd3; id_src1_valid = 1'b1;
    #2;
    check("load_use_ctl", 16'(ctl), 16'(C_RAW));
    tick();
    exp_sc++;
    clear_inputs();
    #2;
    check("load_use_after_ctl", 16'(ctl), 16'(C_NONE));
    check("load_use_stall_cnt", stall_cnt, 16'(exp_sc));

    // MEM-stage dependency: stalls only without forwarding.
    mem_wb_en = 1'b1; mem_dest = 3'd5; id_src2 = 3'd5; id_src2_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #2;
      check("mem_dep_ctl", 16'(ctl), FWD ? 16'(C_NONE) : 16'(C_RAW));
      tick();
      if (!FWD) exp_sc++;
    end
    check("mem_dep_stall_cnt", stall_cnt, 16'(exp_sc));

    // Register 0 never creates a hazard.
    clear_inputs();
    id_src1 = 3'd0; id_src1_valid = 1'b1; id_src2 = 3'd0; id_src2_valid = 1'b1;
    ex_dest = 3'd0; ex_wb_en = 1'b1; ex_is_ld = 1'b1; mem_dest = 3'd0; mem_wb_en = 1'b1;
    #2;
    check("reg0_ctl", 16'(ctl), 16'(C_NONE));

    // Non-load EX dependency, then same with the source not read.
    clear_inputs();
    ex_wb_en = 1'b1; ex_dest = 3'd4; id_src1 = 3'd4; id_src1_valid = 1'b1;
    #2;
    check("ex_alu_dep_ctl", 16'(ctl), FWD ? 16'(C_NONE) : 16'(C_RAW));
    id_src1_valid = 1'b0;
    #2;
    check("ex_src_invalid_ctl", 16'(ctl), 16'(C_NONE));
    tick();

    // Branch wins over a simultaneous load-use hazard.
    clear_inputs();
    branch_taken = 1'b1; ex_is_ld = 1'b1; ex_wb_en = 1'b1; ex_dest = 3'd2;
    id_src1 = 3'd2; id_src1_valid = 1'b1;
    #2;
    check("branch_hazard_ctl", 16'(ctl), 16'(C_BR));
    tick();
    clear_inputs();
    check("branch_stall_cnt", stall_cnt, 16'(exp_sc));

    // Memory wait: ready low 4 cycles then high.
    mem_req = 1'b1;
    #2;
    check("memw_run_ctl", 16'(ctl), 16'(C_MEM));
    tick();
    exp_sc++;
    check("memw_state", 16'(state), 16'd1);
    branch_taken = 1'b1; ex_is_ld = 1'b1; ex_wb_en = 1'b1; ex_dest = 3'd2;
    id_src1 = 3'd2; id_src1_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      check("memw_wait_ctl", 16'(ctl), 16'(C_MEM));
      tick();
      exp_sc++;
    end
    clear_inputs();
    mem_req = 1'b1; mem_ready = 1'b1;
    #2;
    check("memw_ready_ctl", 16'(ctl), 16'(C_MEM));
    tick();
    exp_sc++;
    clear_inputs();
    #2;
    check("memw_back_state", 16'(state), 16'd0);
    check("memw_mem_err", 16'(mem_err), 16'd0);
    check("memw_stall_cnt", stall_cnt, 16'(exp_sc));
    check("memw_after_ctl", 16'(ctl), 16'(C_NONE));

    // Ready on the last allowed wait cycle beats the timeout.
    mem_req = 1'b1;
    tick();
    exp_sc++;
    repeat (7) begin tick(); exp_sc++; end
    check("last_cycle_state", 16'(state), 16'd1);
    mem_ready = 1'b1;
    tick();
    exp_sc++;
    clear_inputs();
    check("last_cycle_win_state", 16'(state), 16'd0);
    check("last_cycle_mem_err", 16'(mem_err), 16'd0);

    // Timeout into HALT.
    mem_req = 1'b1;
    tick();
    exp_sc++;
    repeat (7) begin tick(); exp_sc++; end
    check("timeout_pre_state", 16'(state), 16'd1);
    tick();
    exp_sc++;
    check("timeout_state", 16'(state), 16'd2);
    check("timeout_mem_err", 16'(mem_err), 16'd1);
    check("timeout_ctl", 16'(ctl), 16'(C_HALT));
    check("timeout_stall_cnt", stall_cnt, 16'(exp_sc));
    mem_ready = 1'b1;
    tick();
    check("halt_sticky_state", 16'(state), 16'd2);
    check("halt_no_count", stall_cnt, 16'(exp_sc));

    // Asynchronous reset mid-HALT.
    #2;
    rst = 1'b1;
    #1;
    check("halt_rst_state", 16'(state), 16'd0);
    check("halt_rst_stall_cnt", stall_cnt, 16'd0);
    check("halt_rst_mem_err", 16'(mem_err), 16'd0);
    check("halt_rst_ctl", 16'(ctl), 16'(C_NONE));
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("post_rst_state", 16'(state), 16'd0);

    // Saturation under a held hazard.
    ex_is_ld = 1'b1; ex_wb_en = 1'b1; ex_dest = 3'd1; id_src1 = 3'd1; id_src1_valid = 1'b1;
    repeat (65534) tick();
    check("sat_near", stall_cnt, 16'hFFFE);
    repeat (70000 - 65534) tick();
    check("sat_hold", stall_cnt, 16'hFFFF);
    check("sat_ctl", 16'(ctl), 16'(C_RAW));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
